conv_seq: RTL and testbench
===========================

// Module: conv_seq
// PURPOSE
// Sequencer for the 3x3 convolution datapath. Walks the pixel index over a MATRIX x MATRIX feature map.
// For each pixel it fetches the 9 neighbour pixels from a synchronous feature RAM and drives the conv
// unit's index, boundary code and enables for one cycle. It then writes the conv result back through a
// ready/enable write port. A dense mode streams 9-element groups instead of 3x3 windows.
// PARAMETERS
// SIZE    11  width of pixel/weight words (matches conv unit)
// ADDR_W  10  feature RAM address width; also width of i and matrix2
// PORTS
// clk        in   1           clock, all state on rising edge
// rst_n      in   1           asynchronous active-low reset
// start      in   1           one-cycle pulse; begins a pass when idle, ignored when busy
// dense_mode in   1           sampled at start; 1 = dense (9 consecutive words), 0 = 3x3 conv
// matrix     in   5           row width (28 typical); sampled at start
// matrix2    in   ADDR_W      total words (784 typical); sampled at start
// rd_en      out  1           feature RAM read strobe
// rd_addr    out  ADDR_W      feature RAM read address; RAM returns data one cycle later
// rd_data    in   SIZE        feature RAM read data
// pix1..pix9 out  SIZE each   captured window: centre, R, L, DL, UR, D, U, DR, UL
// i          out  ADDR_W      current pixel index to conv unit
// prov       out  2           00 interior, 11 left edge (col 0), 10 right edge (col matrix-1)
// conv_en    out  1           one-cycle compute strobe to conv unit
// dense_en   out  1           registered copy of dense_mode for the whole pass
// y_in       in   2*SIZE-1    conv unit result Y1 (valid the cycle after conv_en)
// wr_en      out  1           result write request, held until accepted
// wr_addr    out  ADDR_W      result address (= i conv mode, = i/9 group count dense mode)
// wr_data    out  2*SIZE-1    = y_in, passed through combinationally while in WRITE
// wr_ready   in   1           write accept; transfer when wr_en & wr_ready
// busy       out  1           high from start acceptance until done
// done       out  1           one-cycle pulse after last write accepted
// BEHAVIOUR
// - Reset: state IDLE; i, col, slot k, wr_addr, pix1..9 = 0; prov=00; rd_en, conv_en, dense_en, wr_en, busy, done = 0.
// - Reset mid-pass aborts immediately to IDLE; no further reads or writes are issued.
// - States: IDLE -> FETCH -> CAPTURE -> CONV -> WRITE -> (FETCH | DONE) -> IDLE.
// - IDLE: on start latch matrix, matrix2, dense_mode; if matrix2==0 or (conv mode and matrix==0), go to DONE directly.
// - FETCH: 9 cycles, slot k=0..8; drive rd_addr for slot k; capture rd_data into slot k-1 (k>0).
// - Conv-mode slot addresses: i, i+1, i-1, i+m-1, i-m+1, i+m, i-m, i+m+1, i-m-1 (m=matrix).
// - Out-of-map slot (row 0 up-refs, last row down-refs, col 0 left-refs, col m-1 right-refs): rd_en=0, rd_addr=i, slot loads 0.
// - Dense mode: slot k address i+k; rd_en=0 and slot loads 0 where i+k >= matrix2; prov forced 00.
// - CAPTURE: 1 cycle, stores slot 8. CONV: 1 cycle, conv_en=1; i, prov, pix stable.
// - WRITE: wr_en=1 until wr_ready; i, prov, pix held while stalled; a transfer in the first WRITE cycle costs no stall.
// - Throughput: 12 cycles/pixel with wr_ready tied high.
// - Advance after a write: conv mode i+=1 with col wrap at m-1 (col tracked by counter, no divider); dense mode i+=9, wr_addr+=1.
// - Termination: after a write, if next i >= matrix2 go to DONE (done=1 one cycle, busy=0 next), else FETCH.
// - prov is derived from col: col==0 -> 11; col==m-1 -> 10; both when m==1 -> 11 wins.
// - Arithmetic: address math in ADDR_W+1 bits signed; a slot is out-of-map if its result is <0 or >=matrix2.
// - start during busy ignored; start coincident with done ignored (accepted only in IDLE).
// STRUCTURE
// - Shared include conv_defs: PROV_NONE=2'b00, PROV_RIGHT=2'b10, PROV_LEFT=2'b11, state encodings, slot index constants S_C..S_UL.
// - One sub-module conv_addr_gen: combinational (i, col, row_first, row_last, k, m, matrix2, dense) -> (rd_addr, rd_valid).
// - Top holds FSM, i/col/k counters, pix register bank, write handshake.
// TESTING
// - 4x4 map, matrix=4, matrix2=16, RAM[a]=a+1, wr_ready=1 -> 16 writes addr 0..15; i=0 pix = {1,2,0,0,0,5,0,6,0}, prov=11.
// - Same map, i=7 (right edge) -> prov=10, pix R/UR/DR = 0, pix U=4, pix D=12; done pulses once, 192 cycles start->done.
// - wr_ready low 5 cycles at i=5 -> wr_en held, wr_addr=5, i/pix stable, no rd_en, no conv_en; resumes with i=6.
// - Dense mode, matrix2=20 -> 3 writes (wr_addr 0,1,2), third group slots 2..8 = 0, prov=00, dense_en=1 throughout.
// - rst_n low during FETCH of i=3 -> all outputs at reset value asynchronously; new start restarts at i=0.
// - matrix2=0 start -> busy 1 cycle, done pulse, zero reads/writes; start while busy -> no effect.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// Shared definitions for the 3x3 convolution sequencer: FSM states, boundary codes and
// neighbour slot indices.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StCapture,
    StConv,
    StWrite,
    StDone
  } state_e;

  localparam logic [1:0] ProvNone  = 2'b00;
  localparam logic [1:0] ProvRight = 2'b10;
  localparam logic [1:0] ProvLeft  = 2'b11;

  // Window slots in fetch order: centre, R, L, DL, UR, D, U, DR, UL.
  localparam logic [3:0] SlotC  = 4'd0;
  localparam logic [3:0] SlotR  = 4'd1;
  localparam logic [3:0] SlotL  = 4'd2;
  localparam logic [3:0] SlotDl = 4'd3;
  localparam logic [3:0] SlotUr = 4'd4;
  localparam logic [3:0] SlotD  = 4'd5;
  localparam logic [3:0] SlotU  = 4'd6;
  localparam logic [3:0] SlotDr = 4'd7;
  localparam logic [3:0] SlotUl = 4'd8;

  localparam int unsigned NumSlots = 9;

endpackage

// File: rtl/conv_addr_gen.sv
// Combinational feature-RAM address generator for one window slot, with out-of-map masking.
module conv_addr_gen
  import conv_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] i,
  input  logic [4:0]        col,
  input  logic              row_first,
  input  logic              row_last,
  input  logic [3:0]        k,
  input  logic [4:0]        m,
  input  logic [ADDR_W-1:0] matrix2,
  input  logic              dense,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid
);

  logic signed [ADDR_W:0] base, lim, m_s, one_s, off, sum;
  logic up, down, left, right, col_first, col_last, in_map;

  assign base      = signed'({1'b0, i});
  assign lim       = signed'({1'b0, matrix2});
  assign m_s       = signed'({{(ADDR_W-4){1'b0}}, m});
  assign one_s     = signed'({{ADDR_W{1'b0}}, 1'b1});
  assign col_first = (col == 5'd0);
  assign col_last  = (col == m - 5'd1);

  always_comb begin
    off   = '0;
    up    = 1'b0;
    down  = 1'b0;
    left  = 1'b0;
    right = 1'b0;
    if (dense) begin
      off = signed'({{(ADDR_W-3){1'b0}}, k});
    end else begin
      unique case (k)
        SlotC:  ;
        SlotR:  begin off = one_s;         right = 1'b1;               end
        SlotL:  begin off = -one_s;        left  = 1'b1;               end
        SlotDl: begin off = m_s - one_s;   down  = 1'b1; left  = 1'b1; end
        SlotUr: begin off = one_s - m_s;   up    = 1'b1; right = 1'b1; end
        SlotD:  begin off = m_s;           down  = 1'b1;               end
        SlotU:  begin off = -m_s;          up    = 1'b1;               end
        SlotDr: begin off = m_s + one_s;   down  = 1'b1; right = 1'b1; end
        SlotUl: begin off = -m_s - one_s;  up    = 1'b1; left  = 1'b1; end
        default: ;
      endcase
    end
    sum    = base + off;
    in_map = !sum[ADDR_W] && (sum < lim);
    // Edge flags catch column wrap-around that the linear range check alone would miss.
    rd_valid = in_map && (dense || !((up && row_first) || (down && row_last) ||
                                     (left && col_first) || (right && col_last)));
    rd_addr  = rd_valid ? sum[ADDR_W-1:0] : i;
  end

endmodule

// File: rtl/conv_seq.sv
// Convolution sequencer: walks pixels, fetches 3x3 windows (or dense 9-word groups) from the
// feature RAM, strobes the conv unit and writes each result back through a ready/enable port.
module conv_seq
  import conv_seq_pkg::*;
#(
  parameter int unsigned SIZE   = 11,
  parameter int unsigned ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                dense_mode,
  input  logic [4:0]          matrix,
  input  logic [ADDR_W-1:0]   matrix2,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [SIZE-1:0]     rd_data,
  output logic [SIZE-1:0]     pix1,
  output logic [SIZE-1:0]     pix2,
  output logic [SIZE-1:0]     pix3,
  output logic [SIZE-1:0]     pix4,
  output logic [SIZE-1:0]     pix5,
  output logic [SIZE-1:0]     pix6,
  output logic [SIZE-1:0]     pix7,
  output logic [SIZE-1:0]     pix8,
  output logic [SIZE-1:0]     pix9,
  output logic [ADDR_W-1:0]   i,
  output logic [1:0]          prov,
  output logic                conv_en,
  output logic                dense_en,
  input  logic [2*SIZE-2:0]   y_in,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [2*SIZE-2:0]   wr_data,
  input  logic                wr_ready,
  output logic                busy,
  output logic                done
);

  state_e            state_q, state_d;
  logic [3:0]        k_q;
  logic [ADDR_W-1:0] i_q, wr_addr_q, m2_q;
  logic [4:0]        col_q, m_q;
  logic              dense_q, prev_valid_q;
  logic [SIZE-1:0]   pix_q [NumSlots];

  logic [ADDR_W-1:0] gen_addr;
  logic              gen_valid, row_first, row_last, last_pix, start_empty;
  logic [ADDR_W:0]   m_ext, i_next;

  assign m_ext       = {{(ADDR_W-4){1'b0}}, m_q};
  assign row_first   = {1'b0, i_q} < m_ext;
  assign row_last    = ({1'b0, i_q} + m_ext) >= {1'b0, m2_q};
  assign i_next      = {1'b0, i_q} + (dense_q ? (ADDR_W+1)'(9) : (ADDR_W+1)'(1));
  assign last_pix    = i_next >= {1'b0, m2_q};
  assign start_empty = (matrix2 == '0) || (!dense_mode && matrix == 5'd0);

  conv_addr_gen #(
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .i         (i_q),
    .col       (col_q),
    .row_first (row_first),
    .row_last  (row_last),
    .k         (k_q),
    .m         (m_q),
    .matrix2   (m2_q),
    .dense     (dense_q),
    .rd_addr   (gen_addr),
    .rd_valid  (gen_valid)
  );

  always_comb begin
    state_d = state_q;
    rd_en   = 1'b0;
    rd_addr = '0;
    conv_en = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    done    = 1'b0;
    busy    = (state_q != StIdle);
    prov    = ProvNone;
    if (state_q != StIdle && state_q != StDone && !dense_q) begin
      if (col_q == 5'd0)             prov = ProvLeft;
      else if (col_q == m_q - 5'd1)  prov = ProvRight;
    end
    unique case (state_q)
      StIdle: begin
        if (start) state_d = start_empty ? StDone : StFetch;
      end
      StFetch: begin
        rd_en   = gen_valid;
        rd_addr = gen_addr;
        if (k_q == SlotUl) state_d = StCapture;
      end
      StCapture: state_d = StConv;
      StConv: begin
        conv_en = 1'b1;
        state_d = StWrite;
      end
      StWrite: begin
        wr_en   = 1'b1;
        wr_data = y_in;
        if (wr_ready) state_d = last_pix ? StDone : StFetch;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      k_q          <= '0;
      i_q          <= '0;
      col_q        <= '0;
      m_q          <= '0;
      m2_q         <= '0;
      wr_addr_q    <= '0;
      dense_q      <= 1'b0;
      prev_valid_q <= 1'b0;
      for (int s = 0; s < NumSlots; s++) pix_q[s] <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            m_q       <= matrix;
            m2_q      <= matrix2;
            dense_q   <= dense_mode;
            i_q       <= '0;
            col_q     <= '0;
            k_q       <= '0;
            wr_addr_q <= '0;
          end
        end
        StFetch: begin
          k_q          <= (k_q == SlotUl) ? 4'd0 : k_q + 4'd1;
          prev_valid_q <= gen_valid;
          // RAM data lags the address by one cycle, so slot k-1 lands now.
          if (k_q != SlotC) pix_q[k_q - 4'd1] <= prev_valid_q ? rd_data : '0;
        end
        StCapture: pix_q[SlotUl] <= prev_valid_q ? rd_data : '0;
        StWrite: begin
          if (wr_ready) begin
            i_q       <= i_next[ADDR_W-1:0];
            wr_addr_q <= dense_q ? wr_addr_q + ADDR_W'(1) : i_next[ADDR_W-1:0];
            if (!dense_q) col_q <= (col_q == m_q - 5'd1) ? 5'd0 : col_q + 5'd1;
          end
        end
        StDone: dense_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign i        = i_q;
  assign wr_addr  = wr_addr_q;
  assign dense_en = dense_q;
  assign pix1     = pix_q[SlotC];
  assign pix2     = pix_q[SlotR];
  assign pix3     = pix_q[SlotL];
  assign pix4     = pix_q[SlotDl];
  assign pix5     = pix_q[SlotUr];
  assign pix6     = pix_q[SlotD];
  assign pix7     = pix_q[SlotU];
  assign pix8     = pix_q[SlotDr];
  assign pix9     = pix_q[SlotUl];

endmodule

// File: tb/tb_conv_seq.sv
// Self-checking bench for conv_seq: table-driven passes, hand-written corner sequences and
// randomized passes checked against a row/column reference model of the window rules.
module tb_conv_seq;
  localparam int unsigned SIZE   = 11;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned YW     = 2*SIZE-1;

  logic              clk = 1'b0, rst_n = 1'b0, start = 1'b0, dense_mode = 1'b0;
  logic [4:0]        matrix = '0;
  logic [ADDR_W-1:0] matrix2 = '0;
  logic              rd_en, conv_en, dense_en, wr_en, busy, done;
  logic [ADDR_W-1:0] rd_addr, i, wr_addr;
  logic [SIZE-1:0]   rd_data = '0;
  logic [SIZE-1:0]   pix1, pix2, pix3, pix4, pix5, pix6, pix7, pix8, pix9;
  logic [1:0]        prov;
  logic [YW-1:0]     y_in, wr_data;
  logic              wr_ready = 1'b1;

  logic [SIZE-1:0]   ram [1024];
  int tests = 0, fails = 0;
  int m_cur, m2_cur, exp_i, exp_wa, exp_wr_g, n_wr, n_conv, n_rd, wr_seq = 0;
  bit dense_cur, mon_on = 1'b0, release_hold = 1'b0;
  int ready_mode = 0;
  logic [ADDR_W-1:0] hold_i = '0;

  conv_seq #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dense_mode(dense_mode), .matrix(matrix),
    .matrix2(matrix2), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pix1(pix1), .pix2(pix2), .pix3(pix3), .pix4(pix4), .pix5(pix5), .pix6(pix6),
    .pix7(pix7), .pix8(pix8), .pix9(pix9), .i(i), .prov(prov), .conv_en(conv_en),
    .dense_en(dense_en), .y_in(y_in), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];
  assign y_in = YW'(wr_seq * 5 + 3);

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       wr_ready = 1'b1;
      1:       wr_ready = ($urandom_range(0, 3) != 0);
      default: wr_ready = (i != hold_i) || release_hold;
    endcase
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SIZE-1:0] model_pix(input int idx, input int k);
    int r, c, dr, dc, rows;
    if (dense_cur) return (idx + k < m2_cur) ? ram[ADDR_W'(idx + k)] : '0;
    rows = m2_cur / m_cur;
    r = idx / m_cur;
    c = idx % m_cur;
    case (k)
      0: begin dr = 0;  dc = 0;  end
      1: begin dr = 0;  dc = 1;  end
      2: begin dr = 0;  dc = -1; end
      3: begin dr = 1;  dc = -1; end
      4: begin dr = -1; dc = 1;  end
      5: begin dr = 1;  dc = 0;  end
      6: begin dr = -1; dc = 0;  end
      7: begin dr = 1;  dc = 1;  end
      default: begin dr = -1; dc = -1; end
    endcase
    r += dr;
    c += dc;
    if (r < 0 || r >= rows || c < 0 || c >= m_cur) return '0;
    return ram[ADDR_W'(r * m_cur + c)];
  endfunction

  function automatic logic [9*SIZE-1:0] model_window(input int idx);
    logic [9*SIZE-1:0] w = '0;
    for (int k = 0; k < 9; k++) w = {w[8*SIZE-1:0], model_pix(idx, k)};
    return w;
  endfunction

  function automatic logic [1:0] model_prov(input int idx);
    if (dense_cur) return 2'b00;
    if (idx % m_cur == 0) return 2'b11;
    if (idx % m_cur == m_cur - 1) return 2'b10;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    if (rst_n && mon_on) begin
      if (conv_en) n_conv++;
      if (rd_en) n_rd++;
      if (wr_en && wr_ready) begin
        check("wr_i", i, exp_i);
        check("wr_addr", wr_addr, exp_wa);
        check("wr_data", wr_data, YW'(wr_seq * 5 + 3));
        check("prov", prov, model_prov(exp_i));
        check("dense_en", dense_en, dense_cur);
        check("pix", {pix1, pix2, pix3, pix4, pix5, pix6, pix7, pix8, pix9},
              model_window(exp_i));
        wr_seq++;
        n_wr++;
        exp_i += dense_cur ? 9 : 1;
        exp_wa = dense_cur ? exp_wa + 1 : exp_i;
      end
    end
  end

  task automatic fill_ram(input bit rnd);
    for (int a = 0; a < 1024; a++) ram[a] = rnd ? SIZE'($urandom) : SIZE'(a + 1);
  endtask

  task automatic start_pass(input bit d, input int m, input int m2, input int nwr);
    m_cur = m; m2_cur = m2; dense_cur = d; exp_i = 0; exp_wa = 0; exp_wr_g = nwr;
    n_wr = 0; n_conv = 0; n_rd = 0; mon_on = 1'b1;
    @(posedge clk); #1;
    dense_mode = d; matrix = 5'(m); matrix2 = ADDR_W'(m2); start = 1'b1;
    @(posedge clk); #1;
    // Scramble the pass inputs so a missed latch shows up.
    start = 1'b0; dense_mode = ~d; matrix = 5'(m + 3); matrix2 = ADDR_W'(m2 + 7);
  endtask

  task automatic finish_pass(input int exp_cyc, input bit mid);
    int cyc = 0;
    bit got = 1'b0;
    while (!got && cyc < 40 * m2_cur + 100) begin
      @(negedge clk);
      cyc++;
      if (mid && cyc == 20) start = 1'b1;
      if (mid && cyc == 21) start = 1'b0;
      if (done) got = 1'b1;
    end
    check("done_seen", got, 1);
    if (exp_cyc > 0) check("latency", cyc, exp_cyc);
    @(negedge clk);
    check("done_once", {done, busy}, 2'b00);
    check("writes", n_wr, exp_wr_g);
    check("conv_pulses", n_conv, exp_wr_g);
    mon_on = 1'b0;
  endtask

  typedef struct {
    bit d;
    int m;
    int m2;
    int wr;
    int cyc;
  } vec_t;

  initial begin
    vec_t tbl[8];
    logic [9*SIZE-1:0] snap;
    int cyc;
    tbl[0] = '{0, 4, 16, 16, 193};
    tbl[1] = '{1, 4, 20, 3, 37};
    tbl[2] = '{0, 3, 9, 9, 109};
    tbl[3] = '{0, 1, 5, 5, 61};
    tbl[4] = '{0, 0, 16, 0, 1};
    tbl[5] = '{0, 4, 0, 0, 1};
    tbl[6] = '{1, 0, 9, 1, 13};
    tbl[7] = '{0, 8, 8, 8, 97};

    fill_ram(1'b0);
    repeat (2) @(negedge clk);
    check("reset_state", {busy, done, rd_en, wr_en, conv_en, dense_en, prov, i, wr_addr,
                          pix1, pix2, pix3, pix4, pix5, pix6, pix7, pix8, pix9}, '0);
    rst_n = 1'b1;

    for (int t = 0; t < 8; t++) begin
      start_pass(tbl[t].d, tbl[t].m, tbl[t].m2, tbl[t].wr);
      finish_pass(tbl[t].cyc, t == 0);
    end

    // Empty pass, with start held across the done cycle.
    start_pass(1'b0, 4, 0, 0);
    @(negedge clk);
    check("empty_busy_done", {busy, done}, 2'b11);
    start = 1'b1; matrix = 5'd4; matrix2 = ADDR_W'(16);
    @(negedge clk);
    check("start_at_done", {busy, done}, 2'b00);
    start = 1'b0;
    @(negedge clk);
    check("empty_io", {busy, n_rd[7:0], n_wr[7:0]}, '0);
    mon_on = 1'b0;

    // Write stall at i=5.
    ready_mode = 2; hold_i = ADDR_W'(5); release_hold = 1'b0;
    start_pass(1'b0, 4, 16, 16);
    cyc = 0;
    while (!(wr_en && i == 5) && cyc < 200) begin @(negedge clk); cyc++; end
    check("stall_reach", {wr_en, i}, {1'b1, 10'd5});
    snap = {pix1, pix2, pix3, pix4, pix5, pix6, pix7, pix8, pix9};
    for (int s = 0; s < 5; s++) begin
      check("stall_hold", {wr_en, wr_addr, i, rd_en, conv_en}, {1'b1, 10'd5, 10'd5, 2'b00});
      check("stall_pix", {pix1, pix2, pix3, pix4, pix5, pix6, pix7, pix8, pix9}, snap);
      @(negedge clk);
    end
    release_hold = 1'b1;
    repeat (2) @(negedge clk);
    check("stall_resume", {wr_en, i}, {1'b0, 10'd6});
    finish_pass(0, 1'b0);
    ready_mode = 0; release_hold = 1'b0;

    // Asynchronous reset during the fetch of i=3, then a clean restart.
    start_pass(1'b0, 4, 16, 16);
    cyc = 0;
    while (!(rd_en && i == 3) && cyc < 200) begin @(negedge clk); cyc++; end
    check("abort_reach", {rd_en, i}, {1'b1, 10'd3});
    #1 rst_n = 1'b0;
    #1;
    check("async_reset", {busy, done, rd_en, wr_en, conv_en, dense_en, prov, i, wr_addr,
                          pix1, pix2, pix3, pix4, pix5, pix6, pix7, pix8, pix9}, '0);
    mon_on = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_pass(1'b0, 4, 16, 16);
    finish_pass(193, 1'b0);

    // Randomized passes with random write back-pressure.
    ready_mode = 1;
    for (int t = 0; t < 8; t++) begin
      bit d;
      int m, m2;
      d  = 1'($urandom_range(0, 1));
      m  = $urandom_range(1, 8);
      m2 = d ? $urandom_range(1, 40) : m * $urandom_range(1, 5);
      fill_ram(1'b1);
      start_pass(d, m, m2, d ? (m2 + 8) / 9 : m2);
      finish_pass(0, t == 0);
    end
    ready_mode = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
